asm_pass_sequencer: RTL and testbench

Sequences the two-pass assembler over the program text held in the character BRAM. It replays the buffer twice: pass 0 resolves labels, pass 1 encodes instructions. Each character is presented downstream with a valid/ready handshake, together with line-start strobes and the running instruction PC. It sits between the UART-loaded character buffer and the label table / instruction encoder.

---
 rtl/asm_pass_sequencer.sv | 173 +++++++++++++++++
 tb/tb_asm_pass_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asm_pass_sequencer.sv
// Replays the program text buffer twice for the two-pass assembler,
// tagging each character with line-start and the running instruction PC.
module asm_pass_sequencer #(
  parameter int NUMBER_LINES = 256,
  parameter int MAX_CHARS    = 4096,
  parameter int BRAM_LATENCY = 2
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            start_in,
  input  logic [$clog2(MAX_CHARS):0]      char_count_in,
  output logic [$clog2(MAX_CHARS)-1:0]    char_addr_out,
  input  logic [7:0]                      char_data_in,
  output logic                            char_valid_out,
  output logic [7:0]                      char_out,
  output logic                            new_line_out,
  output logic                            pass_out,
  input  logic                            ready_in,
  output logic [$clog2(NUMBER_LINES)+1:0] pc_out,
  output logic                            busy_out,
  output logic                            done_out,
  output logic                            error_out
);
  localparam int AW = $clog2(MAX_CHARS);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(NUMBER_LINES) + 2;
  localparam int LW = $clog2(BRAM_LATENCY + 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(MAX_CHARS);
  localparam logic [PW-1:0] PC_MAX    = PW'(4 * (NUMBER_LINES - 1));
  localparam logic [LW-1:0] WAIT_INIT = LW'(BRAM_LATENCY);
  localparam logic [7:0]    LF        = 8'h0A;
  localparam logic [7:0]    COLON     = 8'h3A;

  // state    | meaning
  // IDLE     | waiting for start_in
  // FETCH    | address driven, counting down BRAM latency
  // PRESENT  | char_valid_out high, waiting for ready_in
  // PASS_END | one cycle between label pass and encode pass
  // FINISH   | one cycle, pulses done_out
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PRESENT, S_PASS_END, S_FINISH} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [CW-1:0] index;
  logic [CW-1:0] index_next;
  logic [LW-1:0] wait_cnt;
  logic          line_start;
  logic          lead;
  logic          instr;
  logic          pc_full;

  assign index_next = index + CW'(1);

  function automatic logic is_letter(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A);
  endfunction

  function automatic logic is_blank(input logic [7:0] c);
    return (c == 8'h20) || (c == 8'h09);
  endfunction

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= S_IDLE;
      count          <= '0;
      index          <= '0;
      wait_cnt       <= '0;
      line_start     <= 1'b0;
      lead           <= 1'b0;
      instr          <= 1'b0;
      pc_full        <= 1'b0;
      char_addr_out  <= '0;
      char_valid_out <= 1'b0;
      char_out       <= '0;
      new_line_out   <= 1'b0;
      pass_out       <= 1'b0;
      pc_out         <= '0;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
      error_out      <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_in) begin
            count         <= (char_count_in > COUNT_MAX) ? COUNT_MAX : char_count_in;
            error_out     <= 1'b0;
            pass_out      <= 1'b0;
            pc_out        <= '0;
            index         <= '0;
            char_addr_out <= '0;
            wait_cnt      <= WAIT_INIT;
            line_start    <= 1'b1;
            lead          <= 1'b1;
            instr         <= 1'b0;
            pc_full       <= 1'b0;
            busy_out      <= 1'b1;
            state         <= (char_count_in == '0) ? S_FINISH : S_FETCH;
          end
        end
        S_FETCH: begin
          if (wait_cnt == '0) begin
            char_out       <= char_data_in;
            new_line_out   <= line_start;
            char_valid_out <= 1'b1;
            state          <= S_PRESENT;
          end else begin
            wait_cnt <= wait_cnt - LW'(1);
          end
        end
        S_PRESENT: begin
          if (ready_in) begin
            char_valid_out <= 1'b0;
            new_line_out   <= 1'b0;
            index          <= index_next;
            char_addr_out  <= index_next[AW-1:0];
            wait_cnt       <= WAIT_INIT;
            state          <= (index_next == count) ? S_PASS_END : S_FETCH;
            if (char_out == LF) begin
              line_start <= 1'b1;
              lead       <= 1'b1;
              instr      <= 1'b0;
              // PC saturates at the last slot; only a further instruction line overflows
              if (instr) begin
                if (pc_full) begin
                  error_out <= 1'b1;
                  state     <= S_FINISH;
                end else if (pc_out == PC_MAX) begin
                  pc_full <= 1'b1;
                end else begin
                  pc_out <= pc_out + PW'(4);
                end
              end
            end else begin
              line_start <= 1'b0;
              if (lead) begin
                if (!is_blank(char_out)) begin
                  lead  <= 1'b0;
                  instr <= is_letter(char_out);
                end
              end else if (char_out == COLON) begin
                instr <= 1'b0;
              end
            end
          end
        end
        S_PASS_END: begin
          if (!pass_out) begin
            pass_out      <= 1'b1;
            pc_out        <= '0;
            index         <= '0;
            char_addr_out <= '0;
            wait_cnt      <= WAIT_INIT;
            line_start    <= 1'b1;
            lead          <= 1'b1;
            instr         <= 1'b0;
            pc_full       <= 1'b0;
            state         <= S_FETCH;
          end else begin
            state <= S_FINISH;
          end
        end
        S_FINISH: begin
          done_out <= 1'b1;
          busy_out <= 1'b0;
          pass_out <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_asm_pass_sequencer.sv
// Bench for asm_pass_sequencer: u0 main flow with scoreboard, u1 two-line
// PC table overflow at latency 3, u2 latency 1 with count clamping.
`timescale 1ns/1ps
module tb_asm_pass_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // u0: NUMBER_LINES=256, MAX_CHARS=16, BRAM_LATENCY=2
  logic start0 = 1'b0, ready0 = 1'b1;
  logic [4:0] count0 = '0;
  logic [3:0] addr0;
  logic [7:0] data0, ch0;
  logic valid0, nl0, pass0, busy0, done0, err0;
  logic [9:0] pc0;
  // u1: NUMBER_LINES=2, MAX_CHARS=16, BRAM_LATENCY=3
  logic start1 = 1'b0, ready1 = 1'b1;
  logic [4:0] count1 = '0;
  logic [3:0] addr1;
  logic [7:0] data1, ch1;
  logic valid1, nl1, pass1, busy1, done1, err1;
  logic [2:0] pc1;
  // u2: NUMBER_LINES=256, MAX_CHARS=8, BRAM_LATENCY=1
  logic start2 = 1'b0, ready2 = 1'b1;
  logic [3:0] count2 = '0;
  logic [2:0] addr2;
  logic [7:0] data2, ch2;
  logic valid2, nl2, pass2, busy2, done2, err2;
  logic [9:0] pc2;

  asm_pass_sequencer #(.NUMBER_LINES(256), .MAX_CHARS(16), .BRAM_LATENCY(2)) u0 (
    .clk_in(clk), .rst_in(rst), .start_in(start0), .char_count_in(count0),
    .char_addr_out(addr0), .char_data_in(data0), .char_valid_out(valid0), .char_out(ch0),
    .new_line_out(nl0), .pass_out(pass0), .ready_in(ready0), .pc_out(pc0),
    .busy_out(busy0), .done_out(done0), .error_out(err0));
  asm_pass_sequencer #(.NUMBER_LINES(2), .MAX_CHARS(16), .BRAM_LATENCY(3)) u1 (
    .clk_in(clk), .rst_in(rst), .start_in(start1), .char_count_in(count1),
    .char_addr_out(addr1), .char_data_in(data1), .char_valid_out(valid1), .char_out(ch1),
    .new_line_out(nl1), .pass_out(pass1), .ready_in(ready1), .pc_out(pc1),
    .busy_out(busy1), .done_out(done1), .error_out(err1));
  asm_pass_sequencer #(.NUMBER_LINES(256), .MAX_CHARS(8), .BRAM_LATENCY(1)) u2 (
    .clk_in(clk), .rst_in(rst), .start_in(start2), .char_count_in(count2),
    .char_addr_out(addr2), .char_data_in(data2), .char_valid_out(valid2), .char_out(ch2),
    .new_line_out(nl2), .pass_out(pass2), .ready_in(ready2), .pc_out(pc2),
    .busy_out(busy2), .done_out(done2), .error_out(err2));

  // BRAM models with the latency each instance is configured for
  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];
  logic [7:0] mem2 [8];
  logic [7:0] q0a, q0b, q1a, q1b, q1c, q2a;
  always @(posedge clk) begin
    q0a <= mem0[addr0]; q0b <= q0a;
    q1a <= mem1[addr1]; q1b <= q1a; q1c <= q1b;
    q2a <= mem2[addr2];
  end
  assign data0 = q0b;
  assign data1 = q1c;
  assign data2 = q2a;

  logic toggle = 1'b0;
  int rcyc = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      rcyc++;
      ready0 = toggle ? (rcyc % 3 == 0) : 1'b1;
    end
  end

  typedef struct packed {
    logic [7:0] ch;
    logic       nl;
    logic       ps;
    logic [9:0] pc;
  } exp_t;
  exp_t sb[$];
  exp_t held_v, e;
  logic held = 1'b0;
  int done_cnt0 = 0, hs1 = 0, hs2 = 0;
  logic pass_seen1 = 1'b0;

  always @(negedge clk) begin
    if (done0) done_cnt0++;
    if (valid1 && ready1) hs1++;
    if (pass1) pass_seen1 = 1'b1;
    if (valid2 && ready2) hs2++;
    if (!valid0) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_char", ch0, held_v.ch);
        check("hold_new_line", nl0, held_v.nl);
        check("hold_pc", pc0, held_v.pc);
      end
      if (!ready0) begin
        held = 1'b1;
        held_v = {ch0, nl0, pass0, pc0};
      end else begin
        held = 1'b0;
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_char: got char %0h with no expected entry", ch0);
        end else begin
          e = sb.pop_front();
          check("char", ch0, e.ch);
          check("new_line", nl0, e.nl);
          check("pass", pass0, e.ps);
          check("pc", pc0, e.pc);
        end
      end
    end
  end

  task automatic push_main();
    string txt;
    int pcs[11] = '{0, 0, 0, 0, 4, 4, 4, 4, 4, 4, 4};
    bit nls[11] = '{1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0};
    txt = "add\nx:\nsub\n";
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 11; i++)
        sb.push_back({txt[i], nls[i], p[0], 10'(pcs[i])});
  endtask

  function automatic logic get_valid(input int u);
    case (u)
      0: return valid0;
      1: return valid1;
      default: return valid2;
    endcase
  endfunction

  function automatic logic get_done(input int u);
    case (u)
      0: return done0;
      1: return done1;
      default: return done2;
    endcase
  endfunction

  task automatic start_unit(input int u, input int n);
    @(posedge clk); #1;
    case (u)
      0: begin start0 = 1'b1; count0 = 5'(n); end
      1: begin start1 = 1'b1; count1 = 5'(n); end
      default: begin start2 = 1'b1; count2 = 4'(n); end
    endcase
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
  endtask

  // Called one step after the edge that sampled start; latencies count edges from it.
  task automatic run_timed(input int u, output int first_lat, output int done_lat);
    first_lat = -1;
    done_lat = -1;
    for (int k = 0; k < 3000; k++) begin
      if (first_lat < 0 && get_valid(u)) first_lat = k;
      if (get_done(u)) begin
        done_lat = k;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    string t0, t1, t2;
    int f, d, dc;
    t0 = "add\nx:\nsub\n";
    t1 = "a\nb\nc\n";
    t2 = "ab\ncd\nef";
    for (int i = 0; i < 16; i++) mem0[i] = (i < 11) ? t0[i] : 8'h00;
    for (int i = 0; i < 16; i++) mem1[i] = (i < 6) ? t1[i] : 8'h00;
    for (int i = 0; i < 8; i++) mem2[i] = t2[i];

    repeat (2) @(posedge clk); #1;
    check("reset_u0", {valid0, busy0, pass0, done0, err0, nl0, pc0, ch0, addr0}, 0);
    check("reset_u1", {valid1, busy1, done1, err1, pc1}, 0);
    check("reset_u2", {valid2, busy2, done2, err2, pc2}, 0);
    rst = 1'b0;

    // empty buffer
    dc = done_cnt0;
    start_unit(0, 0);
    check("empty_busy_set", busy0, 1);
    check("empty_done_early", done0, 0);
    run_timed(0, f, d);
    check("empty_done_latency", d, 1);
    check("empty_busy_cleared", busy0, 0);
    @(posedge clk); #1;
    check("empty_done_single", done0, 0);
    repeat (2) @(posedge clk); #1;
    check("empty_done_count", done_cnt0 - dc, 1);

    // main buffer, ready always high
    dc = done_cnt0;
    push_main();
    start_unit(0, 11);
    run_timed(0, f, d);
    check("main_first_valid", f, 3);
    check("main_done_latency", d, 91);
    check("main_final_pc", pc0, 8);
    check("main_no_error", err0, 0);
    repeat (2) @(posedge clk); #1;
    check("main_sb_empty", sb.size(), 0);
    check("main_done_count", done_cnt0 - dc, 1);

    // backpressure: ready high one cycle in three
    dc = done_cnt0;
    toggle = 1'b1;
    push_main();
    start_unit(0, 11);
    run_timed(0, f, d);
    check("toggle_done_seen", d >= 0, 1);
    check("toggle_final_pc", pc0, 8);
    toggle = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("toggle_sb_empty", sb.size(), 0);
    check("toggle_done_count", done_cnt0 - dc, 1);

    // start pulsed while busy must be ignored
    dc = done_cnt0;
    push_main();
    start_unit(0, 11);
    fork
      run_timed(0, f, d);
      begin
        repeat (20) @(posedge clk); #1;
        start0 = 1'b1; count0 = 5'd3;
        @(posedge clk); #1;
        start0 = 1'b0;
      end
    join
    check("busy_start_done_latency", d, 91);
    repeat (2) @(posedge clk); #1;
    check("busy_start_sb_empty", sb.size(), 0);
    check("busy_start_done_count", done_cnt0 - dc, 1);

    // asynchronous reset during pass 1, then a clean replay
    dc = done_cnt0;
    push_main();
    start_unit(0, 11);
    for (int k = 0; k < 500 && !pass0; k++) begin
      @(posedge clk); #1;
    end
    check("reached_pass1", pass0, 1);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midpass_reset_outputs", {valid0, busy0, pass0, done0, err0, nl0, pc0, ch0, addr0}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    repeat (3) @(posedge clk); #1;
    check("midpass_reset_no_done", done_cnt0 - dc, 0);
    push_main();
    start_unit(0, 11);
    run_timed(0, f, d);
    check("replay_done_latency", d, 91);
    repeat (2) @(posedge clk); #1;
    check("replay_sb_empty", sb.size(), 0);

    // two-entry PC table overflows on the third instruction line
    hs1 = 0;
    pass_seen1 = 1'b0;
    start_unit(1, 6);
    run_timed(1, f, d);
    check("ovf_first_valid", f, 4);
    check("ovf_done_latency", d, 31);
    check("ovf_error", err1, 1);
    check("ovf_pc_held", pc1, 4);
    check("ovf_busy_dropped", busy1, 0);
    repeat (2) @(posedge clk); #1;
    check("ovf_handshakes", hs1, 6);
    check("ovf_no_pass1", pass_seen1, 0);
    check("ovf_error_sticky", err1, 1);
    start_unit(1, 2);
    check("ovf_error_cleared", err1, 0);
    run_timed(1, f, d);
    check("short_done_latency", d, 23);
    check("short_no_error", err1, 0);

    // latency 1 and count clamped to MAX_CHARS=8
    hs2 = 0;
    start_unit(2, 15);
    run_timed(2, f, d);
    check("lat1_first_valid", f, 2);
    check("clamp_done_latency", d, 51);
    check("clamp_final_pc", pc2, 8);
    repeat (2) @(posedge clk); #1;
    check("clamp_handshakes", hs2, 16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
